// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, the bubble instruction, fetch FSM encoding and the IF/ID payload.
// The IF/ID payload carries a misalign flag only when FETCH_MISALIGN_TRAP_EN is defined.
package riscv_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // TRAP/IDLE are only reachable with the misalign trap built in
  localparam logic [2:0] FETCH = 3'd0;
  localparam logic [2:0] HOLD  = 3'd1;
  localparam logic [2:0] DROP  = 3'd2;
  localparam logic [2:0] TRAP  = 3'd3;
  localparam logic [2:0] IDLE  = 3'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign;
`endif
  } if_id_t;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_if_id_if.sv
// Instruction-memory ready-handshake bus between the fetch stage (master) and memory (slave).
interface fetch_if_id_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (output imem_req, imem_addr, input imem_rdata, imem_ready);
  modport slave  (input imem_req, imem_addr, output imem_rdata, imem_ready);
endinterface

// File: rtl/fetch_if_id_if_id_reg.sv
// IF/ID pipeline register: reset > flush > stall (hold) > load, with bubble insertion when nothing loads.
// Bubbles clear the misalign flag when FETCH_MISALIGN_TRAP_EN is defined.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   stall,
  input  logic   ld_valid,
  input  if_id_t ld,
  output if_id_t q
);

  if_id_t if_id_q, if_id_d;

  // Bubbles keep the previous PC fields; only the instruction and flags change
  always_comb begin
    if_id_d = if_id_q;
    if (flush || (!stall && !ld_valid)) begin
      if_id_d.instr = NOP_INSTR;
      if_id_d.valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      if_id_d.misalign = 1'b0;
`endif
    end else if (!stall) begin
      if_id_d = ld;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_id_q       <= '0;
      if_id_q.instr <= NOP_INSTR;
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign q = if_id_q;

endmodule

// File: rtl/fetch_if_id.sv
// Fetch stage with PC, ready-handshake fetch FSM (FETCH/HOLD/DROP) and IF/ID register.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets via MisalignD.
module fetch_if_id
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_if_id_if.master        imem,
  input  logic                 StallD,
  input  logic                 FlushD,
  input  logic                 PCSrcE,
  input  logic [31:0]          PCTargetE,
  output logic [31:0]          InstrD,
  output logic [31:0]          PCD,
  output logic [31:0]          PCPlus4D,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic                 MisalignD,
`endif
  output logic                 ValidD
);

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] stale_q, stale_d;
  logic [31:0] hold_q, hold_d;
  logic        req, beat;
  logic [31:0] addr;
  logic [31:0] target_pc;
  logic        target_mis;
  logic [2:0]  drop_next;
  logic        ld_valid;
  if_id_t      ld, if_id;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target_pc  = PCTargetE;
  assign target_mis = |PCTargetE[1:0];
  // pc_q already holds the redirect target while the stale beat drains
  assign drop_next  = (|pc_q[1:0]) ? TRAP : FETCH;
`else
  assign target_pc  = PCTargetE & 32'hFFFF_FFFC;
  assign target_mis = 1'b0;
  assign drop_next  = FETCH;
`endif

  // Gating with rst_n drops the request immediately when reset asserts
  assign req  = rst_n && ((state_q == FETCH) || (state_q == DROP));
  assign addr = (state_q == DROP) ? stale_q : pc_q;
  assign beat = req && imem.imem_ready;

  assign imem.imem_req  = req;
  assign imem.imem_addr = addr;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    stale_d     = stale_q;
    hold_d      = hold_q;
    ld          = '0;
    ld.instr    = NOP_INSTR;
    ld.pc       = pc_q;
    ld.pc_plus4 = pc_inc(pc_q);
    ld.valid    = 1'b1;
    ld_valid    = 1'b0;
    if (PCSrcE) begin
      pc_d = target_pc;
      if (req && !imem.imem_ready) begin
        state_d = DROP;
        stale_d = addr;
      end else begin
        state_d = target_mis ? TRAP : FETCH;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (beat) begin
            if (!StallD) begin
              ld.instr = imem.imem_rdata;
              ld_valid = 1'b1;
              pc_d     = pc_inc(pc_q);
            end else begin
              hold_d  = imem.imem_rdata;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (!StallD) begin
            ld.instr = hold_q;
            ld_valid = 1'b1;
            pc_d     = pc_inc(pc_q);
            state_d  = FETCH;
          end
        end
        DROP: begin
          if (beat) state_d = drop_next;
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        TRAP: begin
          if (!StallD) begin
            ld_valid    = 1'b1;
            ld.misalign = 1'b1;
            state_d     = IDLE;
          end
        end
        IDLE: ;
`endif
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      stale_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stale_q <= stale_d;
      hold_q  <= hold_d;
    end
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (FlushD),
    .stall    (StallD),
    .ld_valid (ld_valid),
    .ld       (ld),
    .q        (if_id)
  );

  assign InstrD   = if_id.instr;
  assign PCD      = if_id.pc;
  assign PCPlus4D = if_id.pc_plus4;
  assign ValidD   = if_id.valid;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign MisalignD = if_id.misalign;
`endif

endmodule

// File: tb/tb_fetch_if_id.sv
// Self-checking bench for fetch_if_id: directed scenarios then random stall/flush/redirect/wait traffic
// against a flag-based reference model; exercises the trap path when FETCH_MISALIGN_TRAP_EN is defined.
module tb_fetch_if_id;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        MisalignD;
`endif

  always #5 clk = ~clk;

  fetch_if_id_if bus ();

  fetch_if_id #(.RESET_PC(32'h0), .NOP_INSTR(32'h0000_0013)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem      (bus),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
`ifdef FETCH_MISALIGN_TRAP_EN
    .MisalignD (MisalignD),
`endif
    .ValidD    (ValidD)
  );

  int checks = 0;
  int errors = 0;
  int waits_left = 0;
  bit rand_mode = 1'b0;

  // Reference model: architectural fetch pointer plus pending-work flags
  logic [31:0] m_pc, m_stale, m_held;
  bit          m_holding, m_discard, m_trap, m_idle;
  logic [31:0] e_instr, e_pc, e_pc4;
  bit          e_valid, e_mis;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_stale = 32'h0; m_held = 32'h0;
    m_holding = 0; m_discard = 0; m_trap = 0; m_idle = 0;
    e_instr = NOP_INSTR; e_pc = 32'h0; e_pc4 = 32'h0; e_valid = 0; e_mis = 0;
  endtask

  // One clock: respond as memory, check the request, advance the model, check IF/ID
  task automatic cycle();
    logic        r, rdy, st, fl, ps;
    logic [31:0] a, tgt, ldw, ldpc;
    bit          avail, ldmis;
    bus.imem_ready = (waits_left == 0);
    bus.imem_rdata = mem_word(bus.imem_addr);
    #1;
    r = m_discard || !(m_holding || m_trap || m_idle);
    a = m_discard ? m_stale : m_pc;
    chk("imem_req", {31'b0, bus.imem_req}, {31'b0, r});
    if (r) chk("imem_addr", bus.imem_addr, a);
    rdy = bus.imem_ready; st = StallD; fl = FlushD; ps = PCSrcE; tgt = PCTargetE;
    @(posedge clk);
    avail = 0; ldmis = 0; ldw = NOP_INSTR; ldpc = m_pc;
    if (ps) begin
      m_discard = r && !rdy;
      if (m_discard) m_stale = a;
      m_holding = 0; m_idle = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
      m_pc = tgt; m_trap = (tgt[1:0] != 2'b00);
`else
      m_pc = {tgt[31:2], 2'b00}; m_trap = 0;
`endif
    end else if (m_discard) begin
      if (rdy) m_discard = 0;
    end else if (m_holding) begin
      if (!st) begin avail = 1; ldw = m_held; m_pc = m_pc + 32'd4; m_holding = 0; end
    end else if (m_trap) begin
      if (!st) begin avail = 1; ldmis = 1; m_trap = 0; m_idle = 1; end
    end else if (!m_idle && rdy) begin
      if (!st) begin avail = 1; ldw = mem_word(m_pc); m_pc = m_pc + 32'd4; end
      else begin m_holding = 1; m_held = mem_word(m_pc); end
    end
    if (r && !rdy) waits_left--;
    else if (r && rdy) waits_left = rand_mode ? int'($urandom_range(0, 2)) : 0;
    if (fl) begin
      e_instr = NOP_INSTR; e_valid = 0; e_mis = 0;
    end else if (!st) begin
      if (avail) begin
        e_instr = ldw; e_pc = ldpc; e_pc4 = ldpc + 32'd4; e_valid = 1; e_mis = ldmis;
      end else begin
        e_instr = NOP_INSTR; e_valid = 0; e_mis = 0;
      end
    end
    #1;
    chk("InstrD", InstrD, e_instr);
    chk("PCD", PCD, e_pc);
    chk("PCPlus4D", PCPlus4D, e_pc4);
    chk("ValidD", {31'b0, ValidD}, {31'b0, e_valid});
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("MisalignD", {31'b0, MisalignD}, {31'b0, e_mis});
`endif
  endtask

  initial begin
    rst_n = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 32'h0;
    bus.imem_ready = 1'b0; bus.imem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_instr", InstrD, 32'h0000_0013);
    chk("rst_pcd", PCD, 32'h0);
    chk("rst_pc4", PCPlus4D, 32'h0);
    chk("rst_valid", {31'b0, ValidD}, 32'h0);
    chk("rst_req", {31'b0, bus.imem_req}, 32'h0);
    rst_n = 1;

    // First zero-wait beat at address 0
    cycle();
    chk("t1_instr", InstrD, 32'h0050_0093);
    chk("t1_pcd", PCD, 32'h0);
    chk("t1_pc4", PCPlus4D, 32'h4);
    chk("t1_valid", {31'b0, ValidD}, 32'h1);
    chk("t1_next_addr", bus.imem_addr, 32'h4);

    // Three wait states at address 8
    cycle();
    waits_left = 3;
    repeat (3) begin
      cycle();
      chk("t2_wait_addr", bus.imem_addr, 32'h8);
      chk("t2_bubble", InstrD, 32'h0000_0013);
      chk("t2_bubble_valid", {31'b0, ValidD}, 32'h0);
    end
    cycle();
    chk("t2_instr", InstrD, mem_word(32'h8));
    chk("t2_pcd", PCD, 32'h8);

    // Stall on the completing beat at 0xC
    StallD = 1;
    cycle();
    chk("t3_stall_instr", InstrD, mem_word(32'h8));
    chk("t3_hold_req", {31'b0, bus.imem_req}, 32'h0);
    StallD = 0;
    cycle();
    chk("t3_held_instr", InstrD, mem_word(32'hC));
    chk("t3_held_pcd", PCD, 32'hC);

    // Redirect during a two-wait request at 0x10
    waits_left = 2;
    cycle();
    PCSrcE = 1; PCTargetE = 32'h100;
    cycle();
    PCSrcE = 0;
    chk("t4_drop_addr", bus.imem_addr, 32'h10);
    chk("t4_drop_req", {31'b0, bus.imem_req}, 32'h1);
    cycle();
    chk("t4_no_stale", InstrD, 32'h0000_0013);
    chk("t4_no_stale_valid", {31'b0, ValidD}, 32'h0);
    chk("t4_redirect_addr", bus.imem_addr, 32'h100);
    cycle();
    chk("t4_target_instr", InstrD, mem_word(32'h100));
    chk("t4_target_pcd", PCD, 32'h100);

    // Flush wins over stall
    FlushD = 1; StallD = 1;
    cycle();
    chk("t5_flush_instr", InstrD, 32'h0000_0013);
    chk("t5_flush_valid", {31'b0, ValidD}, 32'h0);
    FlushD = 0; StallD = 0;
    cycle();
    chk("t5_after_flush", InstrD, mem_word(32'h104));

    // PC wrap at the top of the address space
    PCSrcE = 1; PCTargetE = 32'hFFFF_FFFC;
    cycle();
    PCSrcE = 0;
    cycle();
    chk("t6_wrap_pcd", PCD, 32'hFFFF_FFFC);
    chk("t6_wrap_pc4", PCPlus4D, 32'h0);
    chk("t6_wrap_addr", bus.imem_addr, 32'h0);

    // Redirect to a misaligned target
    PCSrcE = 1; PCTargetE = 32'h102;
    cycle();
    PCSrcE = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("t7_trap_req", {31'b0, bus.imem_req}, 32'h0);
    cycle();
    chk("t7_misalign", {31'b0, MisalignD}, 32'h1);
    chk("t7_valid", {31'b0, ValidD}, 32'h1);
    chk("t7_pcd", PCD, 32'h102);
    chk("t7_instr", InstrD, 32'h0000_0013);
    cycle();
    chk("t7_idle_req", {31'b0, bus.imem_req}, 32'h0);
    PCSrcE = 1; PCTargetE = 32'h200;
    cycle();
    PCSrcE = 0;
    cycle();
    chk("t7_resume_pcd", PCD, 32'h200);
`else
    chk("t7_aligned_addr", bus.imem_addr, 32'h100);
    cycle();
    chk("t7_aligned_pcd", PCD, 32'h100);
`endif

    // Random traffic with random wait states
    rand_mode = 1;
    repeat (300) begin
      StallD    = ($urandom_range(0, 3) == 0);
      FlushD    = ($urandom_range(0, 9) == 0);
      PCSrcE    = ($urandom_range(0, 9) == 0);
      PCTargetE = $urandom() & 32'h0000_0FFF;
`ifdef FETCH_MISALIGN_TRAP_EN
      if ($urandom_range(0, 3) != 0) PCTargetE[1:0] = 2'b00;
`endif
      cycle();
    end

    // Reset in the middle of a waiting request
    rand_mode = 0; StallD = 0; FlushD = 0; PCSrcE = 0;
    PCTargetE = 32'h0;
    cycle();
    waits_left = 2;
    PCSrcE = 1;
    cycle();
    PCSrcE = 0;
    rst_n = 0;
    #1;
    chk("t8_req_drop", {31'b0, bus.imem_req}, 32'h0);
    @(posedge clk);
    #1;
    model_reset();
    waits_left = 0;
    chk("t8_rst_instr", InstrD, 32'h0000_0013);
    chk("t8_rst_valid", {31'b0, ValidD}, 32'h0);
    chk("t8_rst_pcd", PCD, 32'h0);
    rst_n = 1;
    cycle();
    chk("t8_restart_instr", InstrD, 32'h0050_0093);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
